// File: rtl/sram_master.sv
// Initiator-side controller for a single-port synchronous SRAM with a one-cycle
// registered read. Takes one byte/half/word load or store at a time over a
// valid/ready handshake, drives lane selects and replicated write data, and
// returns an extended, aligned load result or an alignment error.
module sram_master #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_signed_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              resp_err_o,
  output logic              sram_ce_o,
  output logic              sram_we_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [3:0]        sram_sel_o,
  output logic [DATA_W-1:0] sram_data_o,
  input  logic [DATA_W-1:0] sram_data_i
);

  typedef enum logic [1:0] {StIdle, StAccess, StRdata, StResp} state_e;

  state_e state_q;

  // Attributes of the accepted request needed after the acceptance edge.
  logic       we_q;
  logic [1:0] size_q;
  logic       signed_q;
  logic [1:0] off_q;

  // Registered outputs.
  logic              req_ready_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              resp_err_q;
  logic              sram_ce_q;
  logic              sram_we_q;
  logic [ADDR_W-1:0] sram_addr_q;
  logic [3:0]        sram_sel_q;
  logic [DATA_W-1:0] sram_data_q;

  // Decoded request: legality, lane select and replicated write data.
  logic              req_legal;
  logic [3:0]        req_sel;
  logic [DATA_W-1:0] req_data;

  // Extended load result from the SRAM word, using the latched request shape.
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [DATA_W-1:0] rd_ext;

  // Alignment check and lane/data generation straight from the request inputs.
  always_comb begin
    req_legal = 1'b0;
    req_sel   = 4'b0000;
    req_data  = '0;
    unique case (req_size_i)
      2'd0: begin
        req_legal = 1'b1;
        req_sel   = 4'b0001 << req_addr_i[1:0];
        req_data  = {4{req_wdata_i[7:0]}};
      end
      2'd1: begin
        req_legal = ~req_addr_i[0];
        req_sel   = req_addr_i[1] ? 4'b1100 : 4'b0011;
        req_data  = {2{req_wdata_i[15:0]}};
      end
      2'd2: begin
        req_legal = (req_addr_i[1:0] == 2'b00);
        req_sel   = 4'b1111;
        req_data  = req_wdata_i;
      end
      default: begin
        req_legal = 1'b0;
      end
    endcase
  end

  // Lane extraction and sign/zero extension of the returned SRAM word.
  always_comb begin
    rd_byte = sram_data_i[{off_q, 3'b000} +: 8];
    rd_half = off_q[1] ? sram_data_i[31:16] : sram_data_i[15:0];
    case (size_q)
      2'd0:    rd_ext = {{24{signed_q & rd_byte[7]}}, rd_byte};
      2'd1:    rd_ext = {{16{signed_q & rd_half[15]}}, rd_half};
      default: rd_ext = sram_data_i;
    endcase
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      size_q       <= 2'd0;
      signed_q     <= 1'b0;
      off_q        <= 2'd0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      sram_ce_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_sel_q   <= 4'b0000;
      sram_data_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          req_ready_q <= 1'b1;
          if (req_valid_i && req_ready_q) begin
            req_ready_q <= 1'b0;
            we_q        <= req_we_i;
            size_q      <= req_size_i;
            signed_q    <= req_signed_i;
            off_q       <= req_addr_i[1:0];
            if (req_legal) begin
              state_q     <= StAccess;
              sram_ce_q   <= 1'b1;
              sram_we_q   <= req_we_i;
              sram_addr_q <= {req_addr_i[ADDR_W-1:2], 2'b00};
              sram_sel_q  <= req_sel;
              sram_data_q <= req_data;
            end else begin
              // Error responses skip the SRAM entirely.
              state_q      <= StResp;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end
          end
        end
        StAccess: begin
          sram_ce_q    <= 1'b0;
          sram_we_q    <= 1'b0;
          sram_addr_q  <= '0;
          sram_sel_q   <= 4'b0000;
          sram_data_q  <= '0;
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
          state_q      <= we_q ? StResp : StRdata;
        end
        StRdata: begin
          // SRAM read data is valid during this cycle; capture at its end.
          resp_rdata_q <= rd_ext;
          state_q      <= StResp;
        end
        StResp: begin
          // Valid rises one cycle after entering; data/err are already stable.
          if (!resp_valid_q) begin
            resp_valid_q <= 1'b1;
          end else if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;
  assign sram_ce_o    = sram_ce_q;
  assign sram_we_o    = sram_we_q;
  assign sram_addr_o  = sram_addr_q;
  assign sram_sel_o   = sram_sel_q;
  assign sram_data_o  = sram_data_q;

endmodule

// File: tb/tb_sram_master.sv
// Directed testbench for sram_master with a behavioural single-port SRAM.
module tb_sram_master;

  logic        clk;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_signed_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        sram_ce_o;
  logic        sram_we_o;
  logic [31:0] sram_addr_o;
  logic [3:0]  sram_sel_o;
  logic [31:0] sram_data_o;
  logic [31:0] sram_data_i;

  int n_cmp;
  int n_bad;

  // Observations recorded by run_req.
  logic        ob_ce, ob_we;
  logic [31:0] ob_addr, ob_data, ob_rdata;
  logic [3:0]  ob_sel;
  logic        ob_err, ob_post_valid, ob_post_ready;
  int          ob_lat, ob_ce_cnt;

  sram_master #(
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_size_i  (req_size_i),
    .req_signed_i(req_signed_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o),
    .resp_err_o  (resp_err_o),
    .sram_ce_o   (sram_ce_o),
    .sram_we_o   (sram_we_o),
    .sram_addr_o (sram_addr_o),
    .sram_sel_o  (sram_sel_o),
    .sram_data_o (sram_data_o),
    .sram_data_i (sram_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: byte-lane writes, one-cycle registered reads.
  logic [31:0] mem [0:63];
  logic [31:0] mem_w;
  always @(posedge clk) begin
    if (sram_ce_o) begin
      if (sram_we_o) begin
        mem_w = mem[sram_addr_o[7:2]];
        for (int b = 0; b < 4; b++) begin
          if (sram_sel_o[b]) mem_w[8*b +: 8] = sram_data_o[8*b +: 8];
        end
        mem[sram_addr_o[7:2]] <= mem_w;
      end else begin
        sram_data_i <= mem[sram_addr_o[7:2]];
      end
    end
  end

  // Issue one request with resp_ready held high and record what happens.
  // ob_lat counts falling edges after acceptance until resp_valid is seen.
  task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
    int lat;
    resp_ready_i = 1'b1;
    @(negedge clk);
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_size_i   = size;
    req_signed_i = sgn;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
    @(negedge clk);
    req_valid_i = 1'b0;
    ob_ce     = sram_ce_o;
    ob_we     = sram_we_o;
    ob_addr   = sram_addr_o;
    ob_sel    = sram_sel_o;
    ob_data   = sram_data_o;
    ob_ce_cnt = int'(sram_ce_o);
    lat = 1;
    while (resp_valid_o !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
      ob_ce_cnt += int'(sram_ce_o);
    end
    ob_lat   = lat;
    ob_rdata = resp_rdata_o;
    ob_err   = resp_err_o;
    @(negedge clk);
    ob_post_valid = resp_valid_o;
    ob_post_ready = req_ready_o;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({req_ready_o, resp_valid_o, resp_err_o, sram_ce_o, sram_we_o, sram_sel_o} !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 000000000",
               {req_ready_o, resp_valid_o, resp_err_o, sram_ce_o, sram_we_o, sram_sel_o});
    end
    n_cmp++;
    if ({resp_rdata_o, sram_addr_o, sram_data_o} !== 96'd0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 0", {resp_rdata_o, sram_addr_o, sram_data_o});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: got ready=%b valid=%b want 1 0", req_ready_o, resp_valid_o);
    end
  endtask

  task automatic test_store_word();
    run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    n_cmp++;
    if ({ob_ce, ob_we, ob_sel} !== 6'b11_1111) begin
      n_bad++;
      $display("FAIL sw_ctrl: got ce=%b we=%b sel=%b want 1 1 1111", ob_ce, ob_we, ob_sel);
    end
    n_cmp++;
    if (ob_addr !== 32'h10 || ob_data !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL sw_addr_data: got %h %h want 00000010 deadbeef", ob_addr, ob_data);
    end
    n_cmp++;
    if (ob_lat !== 3 || ob_ce_cnt !== 1) begin
      n_bad++;
      $display("FAIL sw_timing: got lat=%0d ce_cycles=%0d want 3 1", ob_lat, ob_ce_cnt);
    end
    n_cmp++;
    if (ob_err !== 1'b0 || ob_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL sw_resp: got err=%b rdata=%h want 0 0", ob_err, ob_rdata);
    end
    n_cmp++;
    if (ob_post_valid !== 1'b0 || ob_post_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL sw_post: got valid=%b ready=%b want 0 1", ob_post_valid, ob_post_ready);
    end
  endtask

  task automatic test_load_byte();
    run_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    n_cmp++;
    if (ob_rdata !== 32'hFFFFFFDE || ob_err !== 1'b0) begin
      n_bad++;
      $display("FAIL lb_signed: got %h err=%b want ffffffde 0", ob_rdata, ob_err);
    end
    n_cmp++;
    if ({ob_ce, ob_we, ob_sel} !== 6'b10_1000 || ob_addr !== 32'h10) begin
      n_bad++;
      $display("FAIL lb_ctrl: got ce=%b we=%b sel=%b addr=%h want 1 0 1000 00000010",
               ob_ce, ob_we, ob_sel, ob_addr);
    end
    n_cmp++;
    if (ob_lat !== 4 || ob_ce_cnt !== 1) begin
      n_bad++;
      $display("FAIL lb_timing: got lat=%0d ce_cycles=%0d want 4 1", ob_lat, ob_ce_cnt);
    end
    run_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
    n_cmp++;
    if (ob_rdata !== 32'h000000DE) begin
      n_bad++;
      $display("FAIL lbu: got %h want 000000de", ob_rdata);
    end
    run_req(1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
    n_cmp++;
    if (ob_rdata !== 32'h000000BE || ob_sel !== 4'b0010) begin
      n_bad++;
      $display("FAIL lbu_lane1: got %h sel=%b want 000000be 0010", ob_rdata, ob_sel);
    end
  endtask

  task automatic test_half_and_byte_store();
    run_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h00001234);
    n_cmp++;
    if (ob_sel !== 4'b1100 || ob_data !== 32'h12341234 || ob_addr !== 32'h10) begin
      n_bad++;
      $display("FAIL sh: got sel=%b data=%h addr=%h want 1100 12341234 00000010",
               ob_sel, ob_data, ob_addr);
    end
    run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    n_cmp++;
    if (ob_rdata !== 32'h1234BEEF) begin
      n_bad++;
      $display("FAIL lw_after_sh: got %h want 1234beef", ob_rdata);
    end
    run_req(1'b0, 2'd1, 1'b1, 32'h10, 32'h0);
    n_cmp++;
    if (ob_rdata !== 32'hFFFFBEEF || ob_sel !== 4'b0011) begin
      n_bad++;
      $display("FAIL lh_signed: got %h sel=%b want ffffbeef 0011", ob_rdata, ob_sel);
    end
    run_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    n_cmp++;
    if (ob_rdata !== 32'h00001234) begin
      n_bad++;
      $display("FAIL lhu_upper: got %h want 00001234", ob_rdata);
    end
    run_req(1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFFA5);
    n_cmp++;
    if (ob_sel !== 4'b0010 || ob_data !== 32'hA5A5A5A5) begin
      n_bad++;
      $display("FAIL sb: got sel=%b data=%h want 0010 a5a5a5a5", ob_sel, ob_data);
    end
    run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    n_cmp++;
    if (ob_rdata !== 32'h1234A5EF) begin
      n_bad++;
      $display("FAIL lw_after_sb: got %h want 1234a5ef", ob_rdata);
    end
  endtask

  task automatic test_errors();
    run_req(1'b0, 2'd2, 1'b0, 32'h11, 32'h0);
    n_cmp++;
    if (ob_err !== 1'b1 || ob_rdata !== 32'h0 || ob_lat !== 2 || ob_ce_cnt !== 0) begin
      n_bad++;
      $display("FAIL err_word_mis: got err=%b rdata=%h lat=%0d ce=%0d want 1 0 2 0",
               ob_err, ob_rdata, ob_lat, ob_ce_cnt);
    end
    run_req(1'b1, 2'd3, 1'b0, 32'h10, 32'h55555555);
    n_cmp++;
    if (ob_err !== 1'b1 || ob_rdata !== 32'h0 || ob_lat !== 2 || ob_ce_cnt !== 0) begin
      n_bad++;
      $display("FAIL err_size3: got err=%b rdata=%h lat=%0d ce=%0d want 1 0 2 0",
               ob_err, ob_rdata, ob_lat, ob_ce_cnt);
    end
    run_req(1'b0, 2'd1, 1'b0, 32'h13, 32'h0);
    n_cmp++;
    if (ob_err !== 1'b1 || ob_ce_cnt !== 0) begin
      n_bad++;
      $display("FAIL err_half_mis: got err=%b ce=%0d want 1 0", ob_err, ob_ce_cnt);
    end
    n_cmp++;
    if (ob_post_valid !== 1'b0 || ob_post_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL err_post: got valid=%b ready=%b want 0 1", ob_post_valid, ob_post_ready);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    resp_ready_i = 1'b0;
    @(negedge clk);
    req_valid_i  = 1'b1;
    req_we_i     = 1'b0;
    req_size_i   = 2'd2;
    req_signed_i = 1'b0;
    req_addr_i   = 32'h10;
    @(negedge clk);
    req_valid_i = 1'b0;
    lat = 1;
    while (resp_valid_o !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat !== 4) begin
      n_bad++;
      $display("FAIL bp_latency: got %0d want 4", lat);
    end
    // Offer a competing store while the response is stalled.
    req_valid_i = 1'b1;
    req_we_i    = 1'b1;
    req_wdata_i = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (resp_valid_o !== 1'b1 || resp_rdata_o !== 32'h1234A5EF || req_ready_o !== 1'b0
          || sram_ce_o !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold%0d: got valid=%b rdata=%h ready=%b ce=%b want 1 1234a5ef 0 0",
                 i, resp_valid_o, resp_rdata_o, req_ready_o, sram_ce_o);
      end
    end
    req_valid_i  = 1'b0;
    resp_ready_i = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release: got valid=%b ready=%b want 0 1", resp_valid_o, req_ready_o);
    end
    run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    n_cmp++;
    if (ob_rdata !== 32'h1234A5EF) begin
      n_bad++;
      $display("FAIL bp_no_stray_store: got %h want 1234a5ef", ob_rdata);
    end
  endtask

  task automatic test_reset_mid();
    // Reset while the SRAM access is being driven.
    @(negedge clk);
    req_valid_i  = 1'b1;
    req_we_i     = 1'b1;
    req_size_i   = 2'd2;
    req_addr_i   = 32'h20;
    req_wdata_i  = 32'h11111111;
    @(negedge clk);
    req_valid_i = 1'b0;
    n_cmp++;
    if (sram_ce_o !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_access_pre: got ce=%b want 1", sram_ce_o);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready_o, resp_valid_o, resp_err_o, sram_ce_o, sram_we_o, sram_sel_o,
         resp_rdata_o, sram_addr_o, sram_data_o} !== 105'd0) begin
      n_bad++;
      $display("FAIL rst_access: got ce=%b we=%b sel=%b addr=%h data=%h want all 0",
               sram_ce_o, sram_we_o, sram_sel_o, sram_addr_o, sram_data_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Reset during the read-data cycle of a load.
    run_req(1'b1, 2'd2, 1'b0, 32'h24, 32'h0);
    @(negedge clk);
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    req_addr_i  = 32'h10;
    @(negedge clk);
    req_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready_o, resp_valid_o, resp_err_o, sram_ce_o, sram_we_o, sram_sel_o,
         resp_rdata_o, sram_addr_o, sram_data_o} !== 105'd0) begin
      n_bad++;
      $display("FAIL rst_rdata: got ready=%b valid=%b rdata=%h want all 0",
               req_ready_o, resp_valid_o, resp_rdata_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
        n_bad++;
        $display("FAIL rst_after%0d: got valid=%b ready=%b want 0 1", i, resp_valid_o,
                 req_ready_o);
      end
    end
    run_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    n_cmp++;
    if (ob_rdata !== 32'h0 || ob_lat !== 4) begin
      n_bad++;
      $display("FAIL rst_abandoned_store: got %h lat=%0d want 00000000 4", ob_rdata, ob_lat);
    end
    run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    n_cmp++;
    if (ob_rdata !== 32'h1234A5EF || ob_lat !== 4) begin
      n_bad++;
      $display("FAIL rst_recover: got %h lat=%0d want 1234a5ef 4", ob_rdata, ob_lat);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    sram_data_i  = 32'h0;
    rst_n        = 1'b0;
    req_valid_i  = 1'b0;
    req_we_i     = 1'b0;
    req_size_i   = 2'd0;
    req_signed_i = 1'b0;
    req_addr_i   = 32'h0;
    req_wdata_i  = 32'h0;
    resp_ready_i = 1'b1;
    test_reset();
    test_store_word();
    test_load_byte();
    test_half_and_byte_store();
    test_errors();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
